// File: rtl/pkt_comm_pkg.sv
// Shared constants, receive-FSM states and width helpers for the output-packet stream.
package pkt_comm_pkg;

  localparam logic [7:0] PKT_TYPE_WORD  = 8'h81;
  localparam int         PKT_HDR_WORDS  = 5;
  localparam int         PKT_CSUM_WORDS = 2;

  typedef enum logic [2:0] {
    ST_HDR  = 3'd0,
    ST_HCS0 = 3'd1,
    ST_HCS1 = 3'd2,
    ST_DATA = 3'd3,
    ST_DCS0 = 3'd4,
    ST_DCS1 = 3'd5,
    ST_ERR  = 3'd6
  } rx_state_e;

  // Index of the highest set bit; 0 when v is 0.
  function automatic int msb_index(input longint unsigned v);
    int idx;
    idx = 0;
    for (int i = 0; i < 64; i++) begin
      if (v[i]) idx = i;
    end
    return idx;
  endfunction

  function automatic int width_for(input longint unsigned v);
    return msb_index(v) + 1;
  endfunction

endpackage

// File: rtl/outpkt_rx_csum.sv
// Running 32-bit modular sum of 16-bit words; csum_o is the one's complement of the sum.
// A clear and an add in the same cycle restart the sum with that word.
module outpkt_rx_csum (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,
  input  logic        add_i,
  input  logic [15:0] word_i,
  output logic [31:0] csum_o
);

  logic [31:0] sum_q;
  logic [31:0] sum_d;

  always_comb begin
    sum_d = clr_i ? 32'h0 : sum_q;
    if (add_i) sum_d = sum_d + {16'h0, word_i};
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) sum_q <= '0;
    else       sum_q <= sum_d;
  end

  assign csum_o = ~sum_q;

endmodule

// File: rtl/outpkt_rx.sv
// Output-packet stream receiver: parses the header, verifies both checksums, delivers payload words.
// Optional OUTPKT_RX_CNT_EN adds pkt_count / word_count statistics outputs.
module outpkt_rx
  import pkt_comm_pkg::*;
#(
  parameter logic [7:0]  VERSION      = 8'd1,
  parameter logic [7:0]  PKT_MAX_TYPE = PKT_TYPE_WORD,
  parameter int unsigned PKT_MAX_LEN  = 16 * 65536
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [15:0] din,
  input  logic        wr_en,
  output logic        full,
  output logic [15:0] dout,
  output logic [7:0]  pkt_type,
  output logic [15:0] pkt_id,
  output logic        pkt_end,
  output logic        empty,
  input  logic        rd_en,
  output logic        pkt_done,
  output logic        err_version,
  output logic        err_type,
  output logic        err_len,
  output logic        err_checksum
`ifdef OUTPKT_RX_CNT_EN
  ,
  output logic [15:0] pkt_count,
  output logic [31:0] word_count
`endif
);

  localparam int HCNT_W = width_for(PKT_HDR_WORDS - 1);
  localparam logic [HCNT_W-1:0] H_TYPEVER = HCNT_W'(0);
  localparam logic [HCNT_W-1:0] H_ZERO    = HCNT_W'(1);
  localparam logic [HCNT_W-1:0] H_LEN_LO  = HCNT_W'(2);
  localparam logic [HCNT_W-1:0] H_LEN_HI  = HCNT_W'(3);

  rx_state_e         state_q, state_d;
  logic [HCNT_W-1:0] hcnt_q, hcnt_d;
  logic [15:0]       len_lo_q, len_lo_d;
  logic [22:0]       nwords_q, nwords_d;
  logic [22:0]       pcnt_q, pcnt_d;
  logic [15:0]       csum_lo_q, csum_lo_d;
  logic [7:0]        type_hold_q, type_hold_d;
  logic [7:0]        type_q, type_d;
  logic [15:0]       id_q, id_d;
  logic [15:0]       dout_q, dout_d;
  logic              valid_q, valid_d;
  logic              end_q, end_d;
  logic              done_q, done_d;
  logic              err_ver_q, err_ver_d;
  logic              err_type_q, err_type_d;
  logic              err_len_q, err_len_d;
  logic              err_cs_q, err_cs_d;

  logic        accept;
  logic        rd_fire;
  logic        last_word;
  logic        hdr_start;
  logic        hdr_add;
  logic        pay_add;
  logic [31:0] len_full;
  logic [31:0] hdr_csum;
  logic [31:0] pay_csum;
  logic        ver_bad;
  logic        type_bad;
  logic        len_bad;

  assign full      = (state_q == ST_ERR) | ((state_q == ST_DATA) & valid_q & ~rd_en);
  assign accept    = wr_en & ~full;
  assign rd_fire   = rd_en & valid_q;
  assign len_full  = {8'h0, din[7:0], len_lo_q};
  assign last_word = (pcnt_q + 23'd1) == nwords_q;
  assign hdr_add   = accept & (state_q == ST_HDR);
  assign hdr_start = hdr_add & (hcnt_q == H_TYPEVER);
  assign pay_add   = accept & (state_q == ST_DATA);

  outpkt_rx_csum u_hdr_csum (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (hdr_start),
    .add_i  (hdr_add),
    .word_i (din),
    .csum_o (hdr_csum)
  );

  outpkt_rx_csum u_pay_csum (
    .clk_i  (CLK),
    .rst_i  (RST),
    .clr_i  (hdr_start),
    .add_i  (pay_add),
    .word_i (din),
    .csum_o (pay_csum)
  );

  always_comb begin
    state_d     = state_q;
    hcnt_d      = hcnt_q;
    len_lo_d    = len_lo_q;
    nwords_d    = nwords_q;
    pcnt_d      = pcnt_q;
    csum_lo_d   = csum_lo_q;
    type_hold_d = type_hold_q;
    type_d      = type_q;
    id_d        = id_q;
    done_d      = 1'b0;
    err_cs_d    = err_cs_q;
    ver_bad     = 1'b0;
    type_bad    = 1'b0;
    len_bad     = 1'b0;

    if (accept) begin
      unique case (state_q)
        ST_HDR: begin
          hcnt_d = hcnt_q + 1'b1;
          case (hcnt_q)
            H_TYPEVER: begin
              ver_bad     = din[7:0] != VERSION;
              type_bad    = (din[15:8] < PKT_TYPE_WORD) | (din[15:8] > PKT_MAX_TYPE);
              type_hold_d = din[15:8];
            end
            H_ZERO:   len_bad = din != 16'h0;
            H_LEN_LO: begin
              len_bad  = din[0];
              len_lo_d = din;
            end
            H_LEN_HI: begin
              len_bad  = (din[15:8] != 8'h0) | (len_full == 32'h0) | (len_full > PKT_MAX_LEN);
              nwords_d = len_full[23:1];
            end
            default: begin
              // Packet context switches only once the whole header has arrived.
              type_d  = type_hold_q;
              id_d    = din;
              hcnt_d  = '0;
              state_d = ST_HCS0;
            end
          endcase
          if (ver_bad | type_bad | len_bad) state_d = ST_ERR;
        end
        ST_HCS0: begin
          csum_lo_d = din;
          state_d   = ST_HCS1;
        end
        ST_HCS1: begin
          if ({din, csum_lo_q} != hdr_csum) begin
            err_cs_d = 1'b1;
            state_d  = ST_ERR;
          end else begin
            pcnt_d  = '0;
            state_d = ST_DATA;
          end
        end
        ST_DATA: begin
          pcnt_d = pcnt_q + 23'd1;
          if (last_word) state_d = ST_DCS0;
        end
        ST_DCS0: begin
          csum_lo_d = din;
          state_d   = ST_DCS1;
        end
        ST_DCS1: begin
          if ({din, csum_lo_q} != pay_csum) begin
            err_cs_d = 1'b1;
            state_d  = ST_ERR;
          end else begin
            done_d  = 1'b1;
            state_d = ST_HDR;
          end
        end
        default: ;
      endcase
    end

    err_ver_d  = err_ver_q  | ver_bad;
    err_type_d = err_type_q | type_bad;
    err_len_d  = err_len_q  | len_bad;
  end

  // Single-entry payload register; a write and a read in the same cycle refill it with no bubble.
  always_comb begin
    dout_d  = dout_q;
    valid_d = valid_q;
    end_d   = end_q;
    if (state_d == ST_ERR) begin
      dout_d  = '0;
      valid_d = 1'b0;
      end_d   = 1'b0;
    end else if (pay_add) begin
      dout_d  = din;
      valid_d = 1'b1;
      end_d   = last_word;
    end else if (rd_fire) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= ST_HDR;
      hcnt_q      <= '0;
      len_lo_q    <= '0;
      nwords_q    <= '0;
      pcnt_q      <= '0;
      csum_lo_q   <= '0;
      type_hold_q <= '0;
      type_q      <= '0;
      id_q        <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      end_q       <= 1'b0;
      done_q      <= 1'b0;
      err_ver_q   <= 1'b0;
      err_type_q  <= 1'b0;
      err_len_q   <= 1'b0;
      err_cs_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      hcnt_q      <= hcnt_d;
      len_lo_q    <= len_lo_d;
      nwords_q    <= nwords_d;
      pcnt_q      <= pcnt_d;
      csum_lo_q   <= csum_lo_d;
      type_hold_q <= type_hold_d;
      type_q      <= type_d;
      id_q        <= id_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      end_q       <= end_d;
      done_q      <= done_d;
      err_ver_q   <= err_ver_d;
      err_type_q  <= err_type_d;
      err_len_q   <= err_len_d;
      err_cs_q    <= err_cs_d;
    end
  end

  assign dout         = dout_q;
  assign empty        = ~valid_q;
  assign pkt_end      = end_q;
  assign pkt_type     = type_q;
  assign pkt_id       = id_q;
  assign pkt_done     = done_q;
  assign err_version  = err_ver_q;
  assign err_type     = err_type_q;
  assign err_len      = err_len_q;
  assign err_checksum = err_cs_q;

`ifdef OUTPKT_RX_CNT_EN
  logic [15:0] pkt_count_q;
  logic [31:0] word_count_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pkt_count_q  <= '0;
      word_count_q <= '0;
    end else begin
      if (done_d)  pkt_count_q  <= pkt_count_q + 16'd1;
      if (rd_fire) word_count_q <= word_count_q + 32'd1;
    end
  end

  assign pkt_count  = pkt_count_q;
  assign word_count = word_count_q;
`endif

endmodule

// File: tb/tb_outpkt_rx.sv
// Self-checking bench for outpkt_rx: frames are built from field values, payload expectations
// are queued per packet and compared as words are consumed.
module tb_outpkt_rx;

  logic        CLK = 1'b0;
  logic        RST;
  logic [15:0] din;
  logic        wr_en;
  logic        rd_en;
  logic        full;
  logic [15:0] dout;
  logic [7:0]  pkt_type;
  logic [15:0] pkt_id;
  logic        pkt_end;
  logic        empty;
  logic        pkt_done;
  logic        err_version;
  logic        err_type;
  logic        err_len;
  logic        err_checksum;
`ifdef OUTPKT_RX_CNT_EN
  logic [15:0] pkt_count;
  logic [31:0] word_count;
`endif

  outpkt_rx dut (
    .CLK          (CLK),
    .RST          (RST),
    .din          (din),
    .wr_en        (wr_en),
    .full         (full),
    .dout         (dout),
    .pkt_type     (pkt_type),
    .pkt_id       (pkt_id),
    .pkt_end      (pkt_end),
    .empty        (empty),
    .rd_en        (rd_en),
    .pkt_done     (pkt_done),
    .err_version  (err_version),
    .err_type     (err_type),
    .err_len      (err_len),
    .err_checksum (err_checksum)
`ifdef OUTPKT_RX_CNT_EN
    ,
    .pkt_count    (pkt_count),
    .word_count   (word_count)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [15:0] w;
    bit          barrier;
  } tx_t;

  typedef struct {
    logic [15:0] w;
    logic [15:0] id;
    logic [7:0]  typ;
    logic        last;
  } rx_t;

  tx_t txq[$];
  rx_t expq[$];
  int  checks = 0;
  int  failures = 0;
  int  done_seen = 0;
  int  words_read = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] csum(input logic [15:0] ws[$]);
    logic [31:0] s;
    s = 32'h0;
    foreach (ws[i]) s = s + {16'h0, ws[i]};
    return ~s;
  endfunction

  task automatic push_tx(input logic [15:0] w, input bit barrier);
    tx_t t;
    t.w = w;
    t.barrier = barrier;
    txq.push_back(t);
  endtask

  // Queue a full frame; barrier makes the driver hold H4 until the previous payload is drained.
  task automatic send_pkt(input logic [7:0] typ, input logic [7:0] ver, input logic [23:0] len,
                          input logic [15:0] id, input logic [15:0] pay[$],
                          input logic [31:0] dc_delta, input bit expect_out, input bit barrier);
    logic [15:0] hdr[$];
    logic [31:0] hc;
    logic [31:0] dc;
    rx_t e;
    hdr.push_back({typ, ver});
    hdr.push_back(16'h0);
    hdr.push_back(len[15:0]);
    hdr.push_back({8'h0, len[23:16]});
    hdr.push_back(id);
    hc = csum(hdr);
    dc = csum(pay) + dc_delta;
    foreach (hdr[i]) push_tx(hdr[i], barrier && (i == 4));
    push_tx(hc[15:0], 1'b0);
    push_tx(hc[31:16], 1'b0);
    foreach (pay[i]) begin
      push_tx(pay[i], 1'b0);
      if (expect_out) begin
        e.w    = pay[i];
        e.id   = id;
        e.typ  = typ;
        e.last = (i == pay.size() - 1);
        expq.push_back(e);
      end
    end
    push_tx(dc[15:0], 1'b0);
    push_tx(dc[31:16], 1'b0);
    $display("tx packet type=%0h ver=%0d len=%0d id=%0h words=%0d", typ, ver, len, id, pay.size());
  endtask

  // One clock: entered and left 1 time unit after a rising edge.
  task automatic tick(input int rd_pct);
    rx_t e;
    rd_en = ($urandom_range(0, 99) < rd_pct);
    wr_en = 1'b0;
    #1;
    if (txq.size() > 0 && !full && !(txq[0].barrier && !empty)) begin
      wr_en = 1'b1;
      din   = txq[0].w;
      void'(txq.pop_front());
    end
    #1;
    if (rd_en && !empty) begin
      words_read++;
      chk("word_expected", 32'(expq.size() > 0), 32'd1);
      if (expq.size() > 0) begin
        e = expq.pop_front();
        chk("dout", 32'(dout), 32'(e.w));
        chk("pkt_end", 32'(pkt_end), 32'(e.last));
        chk("pkt_id", 32'(pkt_id), 32'(e.id));
        chk("pkt_type", 32'(pkt_type), 32'(e.typ));
      end
    end
    @(posedge CLK);
    #1;
    if (pkt_done) done_seen++;
  endtask

  task automatic run(input int max_cyc, input int rd_pct, input bit must_drain);
    for (int c = 0; c < max_cyc && (txq.size() > 0 || expq.size() > 0 || !empty); c++) tick(rd_pct);
    if (must_drain) chk("drain_backlog", 32'(txq.size() + expq.size()), 32'd0);
  endtask

  task automatic do_reset();
    RST   = 1'b1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 16'h0;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    txq.delete();
    expq.delete();
    done_seen  = 0;
    words_read = 0;
  endtask

  task automatic check_errs(input string tag, input logic [3:0] exp);
    chk(tag, {28'h0, err_version, err_type, err_len, err_checksum}, {28'h0, exp});
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_full"}, 32'(full), 32'd0);
    chk({tag, "_empty"}, 32'(empty), 32'd1);
    chk({tag, "_dout"}, 32'(dout), 32'd0);
    chk({tag, "_type"}, 32'(pkt_type), 32'd0);
    chk({tag, "_id"}, 32'(pkt_id), 32'd0);
    chk({tag, "_end"}, 32'(pkt_end), 32'd0);
    chk({tag, "_done"}, 32'(pkt_done), 32'd0);
    check_errs({tag, "_errs"}, 4'b0000);
`ifdef OUTPKT_RX_CNT_EN
    chk({tag, "_pkt_count"}, 32'(pkt_count), 32'd0);
    chk({tag, "_word_count"}, word_count, 32'd0);
`endif
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [15:0] pay[$];
    int n;

    do_reset();
    check_reset("reset");

    // T1: basic packet
    pay.delete();
    pay.push_back(16'h0201);
    pay.push_back(16'h0403);
    send_pkt(8'h81, 8'd1, 24'd4, 16'h1234, pay, 32'd0, 1'b1, 1'b0);
    run(200, 100, 1'b1);
    chk("t1_done", done_seen, 32'd1);
    check_errs("t1_errs", 4'b0000);
    chk("t1_id", 32'(pkt_id), 32'h1234);

    // T2: reader stalls, register holds the first word and back-pressures
    done_seen = 0;
    send_pkt(8'h81, 8'd1, 24'd4, 16'h1234, pay, 32'd0, 1'b1, 1'b0);
    for (int c = 0; c < 18; c++) tick(0);
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_empty", 32'(empty), 32'd0);
    chk("t2_hold", 32'(dout), 32'h0201);
    chk("t2_backlog", 32'(txq.size()), 32'd3);
    run(200, 100, 1'b1);
    chk("t2_done", done_seen, 32'd1);

    // T3: bad version
    do_reset();
    send_pkt(8'h81, 8'd2, 24'd4, 16'h0055, pay, 32'd0, 1'b0, 1'b0);
    run(20, 100, 1'b0);
    check_errs("t3_errs", 4'b1000);
    chk("t3_full", 32'(full), 32'd1);
    chk("t3_empty", 32'(empty), 32'd1);
    do_reset();
    check_reset("t3_rst");

    // T4: odd length, oversize length, out-of-range type
    pay.delete();
    pay.push_back(16'hAAAA);
    send_pkt(8'h81, 8'd1, 24'd3, 16'h0004, pay, 32'd0, 1'b0, 1'b0);
    run(20, 100, 1'b0);
    check_errs("t4_odd_errs", 4'b0010);
    chk("t4_odd_full", 32'(full), 32'd1);
    do_reset();
    pay.delete();
    send_pkt(8'h81, 8'd1, 24'h100002, 16'h0005, pay, 32'd0, 1'b0, 1'b0);
    run(20, 100, 1'b0);
    check_errs("t4_max_errs", 4'b0010);
    do_reset();
    pay.push_back(16'h1111);
    send_pkt(8'h82, 8'd1, 24'd2, 16'h0006, pay, 32'd0, 1'b0, 1'b0);
    run(20, 100, 1'b0);
    check_errs("t4_type_errs", 4'b0100);
    chk("t4_type_ctx", 32'(pkt_type), 32'd0);

    // T5: payload checksum off by one
    do_reset();
    pay.delete();
    for (int i = 0; i < 3; i++) pay.push_back(16'($urandom));
    send_pkt(8'h81, 8'd1, 24'd6, 16'h0777, pay, 32'd1, 1'b1, 1'b0);
    run(100, 100, 1'b0);
    chk("t5_delivered", 32'(expq.size()), 32'd0);
    check_errs("t5_errs", 4'b0001);
    chk("t5_done", done_seen, 32'd0);
    chk("t5_empty", 32'(empty), 32'd1);

    // T6: three back-to-back packets, random reader
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      n = $urandom_range(1, 6);
      pay.delete();
      for (int i = 0; i < n; i++) pay.push_back(16'($urandom));
      send_pkt(8'h81, 8'd1, 24'(2 * n), 16'(k), pay, 32'd0, 1'b1, 1'b1);
    end
    run(3000, 50, 1'b1);
    chk("t6_done", done_seen, 32'd3);
    check_errs("t6_errs", 4'b0000);
    chk("t6_last_id", 32'(pkt_id), 32'd3);
`ifdef OUTPKT_RX_CNT_EN
    chk("t6_pkt_count", 32'(pkt_count), 32'd3);
    chk("t6_word_count", word_count, 32'(words_read));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
